core_param_bank: RTL and testbench
==================================

# core_param_bank

Per-chamber parameter store sitting directly downstream of the AXI parameter slave. It consumes that slave's decoded chip-select, region select, word address, write data and write enable, and returns registered read data. It holds a 128-word lookup RAM and eight double-buffered control registers. The chamber's trigger logic reads these through a dedicated lookup port and a flat active-register bus; shadow-to-active commits are aligned to the BX0 boundary.

## Interface
- DW, 64, data word width (matches AXI data width)
- ADDR_W, 7, word address width within a region
- NREG, 8, number of control registers (fixed; addr[2:0] indexes them)

- s_aclk  in  1  clock
- s_aresetn  in  1  reset; asynchronous, active-low
- cs  in  1  this chamber's select bit from the slave's chip-select array
- sel  in  2  region: 0 lookup RAM, 1 shadow regs, 2 active regs (read-only), 3 command/status
- addr  in  ADDR_W  word address within region
- r_in  in  DW  write data
- we  in  1  write strobe; qualified by cs
- r_out  out  DW  registered read data; 0 when not selected
- bx0  in  1  orbit-boundary strobe from the trigger timing logic
- lut_addr  in  ADDR_W  core lookup address
- lut_data  out  DW  core lookup data
- ctrl_active  out  NREG*DW  active register set; reg k at bits [k*DW +: DW]
- commit_pulse  out  1  high for one cycle after each commit

## Operation
- Write accepted on a rising edge with cs=1 and we=1. Writes with cs=0 are ignored.
- sel=0: RAM[addr] <= r_in. The RAM is not reset.
- sel=1: if addr[6:3]==0, shadow[addr[2:0]] <= r_in; otherwise the write is ignored.
- sel=2: writes ignored.
- sel=3, addr==0, command word:
  - bit0=1 sets `armed`.
  - bit1=1 requests an immediate commit on the next edge, independent of bx0.
  - Other bits and other addresses are ignored.
- Read mux: RAM[addr] for sel=0; shadow for sel=1; active for sel=2; status for sel=3/addr 0, where status = {DW-32 zeros, commit_cnt[15:0], 15'h0, armed}. Out-of-map addresses in any region read 0.
- Commit, on an edge where (armed && bx0) or an immediate request is pending:
  - active <= shadow (all NREG at once)
  - armed <= 0
  - commit_cnt <= commit_cnt+1, wrapping 0xFFFF -> 0x0000
  - commit_pulse <= 1
- Lookup port: lut_data <= RAM[lut_addr] every edge (read-first). It has priority over nothing; the RAM is true dual-port, with write on the AXI side and read on the core side.

## Timing
- Reset, asynchronous: r_out=0, lut_data=0, shadow=0, active=0 (so ctrl_active=0), armed=0, commit_cnt=0, commit_pulse=0. Deassertion is synchronous to s_aclk (two-flop synchronizer inside).
- r_out latency is 1 cycle: address/sel/cs sampled at edge N, data valid after edge N. This matches the slave's one-cycle rvalid delay. If cs=0 at edge N, r_out=0 after edge N, so chamber outputs can be OR-combined.
- Read and write to the same location on the same edge: r_out returns the old value (read-first). The same rule applies to lut_data versus an AXI write.
- lut_data latency is 1 cycle.
- Arm write at edge N with bx0=1 at the same edge N: no commit at N; armed=1 after N; commit occurs at the next bx0.
- Shadow write at the same edge as a commit: active receives the pre-write shadow value; shadow holds the new value.
- Arm write while already armed: no effect. bx0 while not armed: no effect.
- Immediate request (bit1) with bit0 in the same word: one commit only, and armed ends at 0.
- commit_pulse is exactly one cycle wide. Back-to-back commits on consecutive edges give consecutive pulses.
- Reset asserted mid-burst: all state listed above clears immediately; RAM contents are retained but undefined-safe.

## Test plan
- Reset then read sel=2 addr 3 and sel=3 addr 0 -> r_out=0 one cycle after each address; ctrl_active=0.
- Write RAM[0x05]=0xDEADBEEF_00000001 with cs=1, then lut_addr=0x05 -> lut_data=0xDEADBEEF_00000001 one cycle later. Repeat the write with cs=0 and value 0x1 -> RAM unchanged.
- Write shadow[2]=0x1234, arm, then pulse bx0 -> ctrl_active reg2=0x1234 after that edge; commit_pulse high one cycle; status reads armed=0, commit_cnt=1.
- Arm write coincident with bx0 -> no commit. Next bx0 -> commit, commit_cnt increments once.
- Shadow write of 0xAA on the same edge as a commit, prior shadow 0x55 -> active=0x55, shadow readback=0xAA.
- Issue 65536 immediate commits -> commit_cnt reads 0x0000. Write to sel=1 addr 0x08 -> no shadow register changes; read of that address returns 0.

Source files
------------

// File: rtl/core_param_bank.sv
// core_param_bank: per-chamber parameter store behind the AXI parameter slave.
// Holds a 128-word lookup RAM with a dedicated core-side read port, eight
// double-buffered control registers (shadow -> active), and a command/status
// word that arms a BX0-aligned commit or requests an immediate one.
module core_param_bank #(
  parameter int unsigned DW     = 64,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned NREG   = 8
) (
  input  logic                s_aclk,
  input  logic                s_aresetn,
  input  logic                cs,
  input  logic [1:0]          sel,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DW-1:0]       r_in,
  input  logic                we,
  output logic [DW-1:0]       r_out,
  input  logic                bx0,
  input  logic [ADDR_W-1:0]   lut_addr,
  output logic [DW-1:0]       lut_data,
  output logic [NREG*DW-1:0]  ctrl_active,
  output logic                commit_pulse
);

  localparam int unsigned RIDX_W = $clog2(NREG);
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    SEL_LUT    = 2'd0,
    SEL_SHADOW = 2'd1,
    SEL_ACTIVE = 2'd2,
    SEL_CMD    = 2'd3
  } region_e;

  region_e region;
  assign region = region_e'(sel);

  // Internal reset: asserts asynchronously, releases two clocks after s_aresetn.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Reset synchronizer: shift ones in once the external reset is released.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // Storage
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] shadow_q [NREG];
  logic [DW-1:0] shadow_d [NREG];
  logic [DW-1:0] active_q [NREG];
  logic [DW-1:0] active_d [NREG];
  logic          armed_q, armed_d;
  logic          imm_req_q, imm_req_d;
  logic [15:0]   commit_cnt_q, commit_cnt_d;
  logic          commit_pulse_q, commit_pulse_d;
  logic [DW-1:0] r_out_q, r_out_d;
  logic [DW-1:0] lut_data_q, lut_data_d;

  // Decode of the slave-side access
  logic          wr;
  logic          reg_in_map;
  logic          cmd_wr;
  logic          commit;
  logic [DW-1:0] status;

  assign wr         = cs && we;
  assign reg_in_map = (addr[ADDR_W-1:RIDX_W] == '0);
  assign cmd_wr     = wr && (region == SEL_CMD) && (addr == '0);
  // A pending immediate request commits regardless of bx0; otherwise an armed
  // bank commits on bx0. The armed flag is sampled pre-write, so an arm write
  // coincident with bx0 waits for the next boundary.
  assign commit     = imm_req_q || (armed_q && bx0);
  assign status     = {{(DW-32){1'b0}}, commit_cnt_q, 15'h0, armed_q};

  // Lookup RAM write port (AXI side).
  // NOTE: the RAM array has no reset so it can map onto block/distributed RAM;
  // its contents survive a reset and only the control state is cleared.
  always_ff @(posedge s_aclk) begin
    if (wr && (region == SEL_LUT)) mem[addr] <= r_in;
  end

  // Next-state for shadow/active registers and commit control.
  // NOTE: every variable written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    for (int k = 0; k < NREG; k++) begin
      shadow_d[k] = shadow_q[k];
      active_d[k] = active_q[k];
    end
    armed_d        = armed_q;
    imm_req_d      = cmd_wr && r_in[1];
    commit_cnt_d   = commit_cnt_q;
    commit_pulse_d = commit;

    if (wr && (region == SEL_SHADOW) && reg_in_map)
      shadow_d[addr[RIDX_W-1:0]] = r_in;

    if (cmd_wr && r_in[0]) armed_d = 1'b1;

    // Commit copies the pre-write shadow set, so a coincident shadow write
    // lands only in shadow.
    if (commit) begin
      for (int k = 0; k < NREG; k++) active_d[k] = shadow_q[k];
      armed_d      = 1'b0;
      commit_cnt_d = commit_cnt_q + 16'd1;
    end
  end

  // Registered read mux; reads see pre-write contents (read-first).
  always_comb begin
    r_out_d = '0;
    if (cs) begin
      unique case (region)
        SEL_LUT:    r_out_d = mem[addr];
        SEL_SHADOW: if (reg_in_map) r_out_d = shadow_q[addr[RIDX_W-1:0]];
        SEL_ACTIVE: if (reg_in_map) r_out_d = active_q[addr[RIDX_W-1:0]];
        SEL_CMD:    if (addr == '0) r_out_d = status;
        default:    r_out_d = '0;
      endcase
    end
  end

  // Core-side lookup read, every cycle.
  always_comb begin
    lut_data_d = mem[lut_addr];
  end

  // State registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge s_aclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      armed_q        <= 1'b0;
      imm_req_q      <= 1'b0;
      commit_cnt_q   <= '0;
      commit_pulse_q <= 1'b0;
      r_out_q        <= '0;
      lut_data_q     <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
      end
      armed_q        <= armed_d;
      imm_req_q      <= imm_req_d;
      commit_cnt_q   <= commit_cnt_d;
      commit_pulse_q <= commit_pulse_d;
      r_out_q        <= r_out_d;
      lut_data_q     <= lut_data_d;
    end
  end

  // Flatten the active set for the trigger logic.
  for (genvar k = 0; k < NREG; k++) begin : g_active
    assign ctrl_active[k*DW +: DW] = active_q[k];
  end

  assign r_out        = r_out_q;
  assign lut_data     = lut_data_q;
  assign commit_pulse = commit_pulse_q;

endmodule

// File: tb/tb_core_param_bank.sv
// Bench for core_param_bank: stimulus issues directed accesses and pushes
// expected read/lookup data into queues; a monitor pops and compares one
// cycle after each issued access.
module tb_core_param_bank;

  localparam int DW = 64;
  localparam int AW = 7;
  localparam int NR = 8;

  logic              clk;
  logic              s_aresetn;
  logic              cs;
  logic [1:0]        sel;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     r_in;
  logic              we;
  logic [DW-1:0]     r_out;
  logic              bx0;
  logic [AW-1:0]     lut_addr;
  logic [DW-1:0]     lut_data;
  logic [NR*DW-1:0]  ctrl_active;
  logic              commit_pulse;

  core_param_bank #(.DW(DW), .ADDR_W(AW), .NREG(NR)) dut (
    .s_aclk       (clk),
    .s_aresetn    (s_aresetn),
    .cs           (cs),
    .sel          (sel),
    .addr         (addr),
    .r_in         (r_in),
    .we           (we),
    .r_out        (r_out),
    .bx0          (bx0),
    .lut_addr     (lut_addr),
    .lut_data     (lut_data),
    .ctrl_active  (ctrl_active),
    .commit_pulse (commit_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] exp;
  } exp_t;

  exp_t rd_q[$];
  exp_t lut_q[$];
  logic rd_req;
  logic lut_req;
  int   total;
  int   bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive just after a negedge, let one posedge pass.
  task automatic bus(input logic c, input logic w, input logic [1:0] s, input logic [AW-1:0] a,
                     input logic [63:0] d, input logic bx, input logic rd,
                     input logic [63:0] rexp, input string nm);
    cs = c; we = w; sel = s; addr = a; r_in = d; bx0 = bx; rd_req = rd;
    if (rd) rd_q.push_back('{name: nm, exp: rexp});
    @(negedge clk);
    cs = 1'b0; we = 1'b0; bx0 = 1'b0; rd_req = 1'b0; lut_req = 1'b0;
  endtask

  task automatic wr(input logic [1:0] s, input logic [AW-1:0] a, input logic [63:0] d);
    bus(1'b1, 1'b1, s, a, d, 1'b0, 1'b0, 64'h0, "");
  endtask

  task automatic rd(input logic [1:0] s, input logic [AW-1:0] a, input logic [63:0] e, input string nm);
    bus(1'b1, 1'b0, s, a, 64'h0, 1'b0, 1'b1, e, nm);
  endtask

  task automatic idle(input logic bx);
    bus(1'b0, 1'b0, 2'd0, '0, 64'h0, bx, 1'b0, 64'h0, "");
  endtask

  // Arms a lookup check for the next bus cycle.
  task automatic lut_set(input logic [AW-1:0] a, input logic [63:0] e, input string nm);
    lut_addr = a; lut_req = 1'b1;
    lut_q.push_back('{name: nm, exp: e});
  endtask

  function automatic logic [63:0] areg(input int k);
    return ctrl_active[k*DW +: DW];
  endfunction

  // Monitor: data for an access issued at an edge is valid right after it.
  initial begin
    logic fire, lfire;
    exp_t e;
    forever begin
      @(posedge clk);
      fire  = rd_req;
      lfire = lut_req;
      #1;
      if (fire) begin
        if (rd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_q: read output with no expected entry");
        end else begin
          e = rd_q.pop_front();
          check(e.name, r_out, e.exp);
        end
      end
      if (lfire) begin
        if (lut_q.size() == 0) begin
          total++; bad++;
          $display("FAIL lut_q: lookup output with no expected entry");
        end else begin
          e = lut_q.pop_front();
          check(e.name, lut_data, e.exp);
        end
      end
    end
  end

  task automatic do_reset();
    s_aresetn = 1'b0;
    repeat (3) @(negedge clk);
    s_aresetn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0;
    cs = 0; we = 0; sel = 0; addr = 0; r_in = 0; bx0 = 0; lut_addr = 0;
    rd_req = 0; lut_req = 0;
    s_aresetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_r_out", r_out, 64'h0);
    check("rst_lut_data", lut_data, 64'h0);
    check("rst_ctrl_active_lo", ctrl_active[255:0], 256'h0);
    check("rst_ctrl_active_hi", ctrl_active[511:256] == '0, 1'b1);
    check("rst_commit_pulse", commit_pulse, 1'b0);
    s_aresetn = 1'b1;
    repeat (3) @(negedge clk);

    // Reset readback.
    rd(2'd2, 7'd3, 64'h0, "rst_active3");
    rd(2'd3, 7'd0, 64'h0, "rst_status");

    // RAM write, lookup and AXI readback; cs=0 write ignored.
    wr(2'd0, 7'h05, 64'hDEADBEEF_00000001);
    lut_set(7'h05, 64'hDEADBEEF_00000001, "lut5");
    idle(1'b0);
    rd(2'd0, 7'h05, 64'hDEADBEEF_00000001, "ram5");
    bus(1'b0, 1'b1, 2'd0, 7'h05, 64'h1, 1'b0, 1'b0, 64'h0, "");
    rd(2'd0, 7'h05, 64'hDEADBEEF_00000001, "ram5_cs0_wr");
    lut_set(7'h05, 64'hDEADBEEF_00000001, "lut5_cs0_wr");
    idle(1'b0);

    // Read-first on both ports.
    wr(2'd0, 7'h06, 64'h11);
    lut_set(7'h06, 64'h11, "lut6_read_first");
    bus(1'b1, 1'b1, 2'd0, 7'h06, 64'h22, 1'b0, 1'b1, 64'h11, "ram6_read_first");
    lut_set(7'h06, 64'h22, "lut6_new");
    idle(1'b0);

    // Shadow write, arm, commit on bx0.
    wr(2'd1, 7'd2, 64'h1234);
    wr(2'd3, 7'd0, 64'h1);
    idle(1'b1);
    check("bx0_commit_pulse", commit_pulse, 1'b1);
    check("bx0_active2", areg(2), 64'h1234);
    idle(1'b0);
    check("pulse_one_cycle", commit_pulse, 1'b0);
    rd(2'd3, 7'd0, 64'h0000_0000_0001_0000, "status_cnt1");

    // Arm coincident with bx0: no commit until the next bx0.
    bus(1'b1, 1'b1, 2'd3, 7'd0, 64'h1, 1'b1, 1'b0, 64'h0, "");
    check("arm_bx0_no_commit", commit_pulse, 1'b0);
    rd(2'd3, 7'd0, 64'h0000_0000_0001_0001, "status_armed");
    idle(1'b1);
    check("next_bx0_commit", commit_pulse, 1'b1);
    rd(2'd3, 7'd0, 64'h0000_0000_0002_0000, "status_cnt2");
    idle(1'b1);
    check("bx0_unarmed", commit_pulse, 1'b0);

    // Shadow write on the commit edge.
    wr(2'd1, 7'd4, 64'h55);
    wr(2'd3, 7'd0, 64'h1);
    bus(1'b1, 1'b1, 2'd1, 7'd4, 64'hAA, 1'b1, 1'b0, 64'h0, "");
    check("coincident_commit", commit_pulse, 1'b1);
    check("coincident_active4", areg(4), 64'h55);
    rd(2'd1, 7'd4, 64'hAA, "coincident_shadow4");
    rd(2'd2, 7'd4, 64'h55, "coincident_rd_active4");
    rd(2'd3, 7'd0, 64'h0000_0000_0003_0000, "status_cnt3");
    bus(1'b0, 1'b0, 2'd2, 7'd4, 64'h0, 1'b0, 1'b1, 64'h0, "rd_cs0_zero");

    // Immediate request with arm in the same word: single commit, disarmed.
    wr(2'd3, 7'd0, 64'h3);
    check("imm_not_yet", commit_pulse, 1'b0);
    idle(1'b0);
    check("imm_commit", commit_pulse, 1'b1);
    check("imm_active4", areg(4), 64'hAA);
    idle(1'b0);
    check("imm_single", commit_pulse, 1'b0);
    rd(2'd3, 7'd0, 64'h0000_0000_0004_0000, "status_imm");

    // Arm while armed is harmless.
    wr(2'd3, 7'd0, 64'h1);
    wr(2'd3, 7'd0, 64'h1);
    check("rearm_no_commit", commit_pulse, 1'b0);
    rd(2'd3, 7'd0, 64'h0000_0000_0004_0001, "status_rearm");
    wr(2'd3, 7'd0, 64'h2);
    idle(1'b0);
    rd(2'd3, 7'd0, 64'h0000_0000_0005_0000, "status_cnt5");

    // Out-of-map accesses.
    wr(2'd1, 7'h08, 64'hFFFF);
    rd(2'd1, 7'h00, 64'h0, "shadow0_after_oob");
    rd(2'd1, 7'h08, 64'h0, "shadow_oob_read");
    rd(2'd1, 7'h02, 64'h1234, "shadow2_intact");
    wr(2'd2, 7'd2, 64'hBAD);
    rd(2'd2, 7'd2, 64'h1234, "active_write_ignored");
    rd(2'd3, 7'd1, 64'h0, "cmd_addr1_zero");
    rd(2'd2, 7'd9, 64'h0, "active_oob_read");

    // Reset in the middle of traffic: control state clears, RAM survives.
    wr(2'd0, 7'd7, 64'h77);
    wr(2'd1, 7'd1, 64'h99);
    s_aresetn = 1'b0;
    #1;
    check("midrst_active2", areg(2), 64'h0);
    check("midrst_active4", areg(4), 64'h0);
    check("midrst_r_out", r_out, 64'h0);
    check("midrst_lut_data", lut_data, 64'h0);
    @(negedge clk);
    s_aresetn = 1'b1;
    repeat (3) @(negedge clk);
    rd(2'd1, 7'd1, 64'h0, "midrst_shadow1");
    rd(2'd3, 7'd0, 64'h0, "midrst_status");
    lut_set(7'd7, 64'h77, "midrst_ram_kept");
    rd(2'd0, 7'h05, 64'hDEADBEEF_00000001, "midrst_ram5");

    // Counter wrap: 65535 back-to-back immediate commits, then one more.
    cs = 1'b1; we = 1'b1; sel = 2'd3; addr = '0; r_in = 64'h2;
    for (int i = 1; i <= 65535; i++) begin
      @(posedge clk);
      #1;
      if (i == 10 || i == 11) check("pulse_back_to_back", commit_pulse, 1'b1);
    end
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
    idle(1'b0);
    rd(2'd3, 7'd0, 64'h0000_0000_FFFF_0000, "status_cnt_ffff");
    wr(2'd3, 7'd0, 64'h2);
    idle(1'b0);
    rd(2'd3, 7'd0, 64'h0, "status_cnt_wrap");

    idle(1'b0);
    idle(1'b0);
    check("rd_q_drained", 64'(rd_q.size()), 64'h0);
    check("lut_q_drained", 64'(lut_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
